// File: rtl/alu_opcodes_pkg.sv
// rtl/alu_opcodes_pkg.sv - opcode and FSM state types shared by the ALU instruction pipe
package alu_opcodes_pkg;
   localparam int OPCODE_W = 3;

   typedef enum logic [OPCODE_W-1:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} alu_state_t;

   function automatic logic is_divide(opcode_t op);
      return (op == DIV) || (op == MOD);
   endfunction
endpackage

// File: rtl/alu_instr_pipe_if.sv
// rtl/alu_instr_pipe_if.sv - load/result handshake bundle; status port only with ALU_STATUS_EN
interface alu_instr_pipe_if #(
   parameter int OP_W  = 8,
   parameter int DEPTH = 4
);
   import alu_opcodes_pkg::*;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                            load_en;
   logic                            load_ready;
   opcode_t                         opcode;
   logic signed [OP_W-1:0]          operand_a;
   logic signed [OP_W-1:0]          operand_b;
   logic                            out_valid;
   logic                            out_ready;
   logic signed [2*OP_W-1:0]        alu_out;
   logic [OPCODE_W+2*OP_W-1:0]      instruction_word;
   logic [CNT_W-1:0]                count;
`ifdef ALU_STATUS_EN
   logic [1:0]                      status;

   modport master (
      output load_en, opcode, operand_a, operand_b, out_ready,
      input  load_ready, out_valid, alu_out, instruction_word, count, status
   );
   modport slave (
      input  load_en, opcode, operand_a, operand_b, out_ready,
      output load_ready, out_valid, alu_out, instruction_word, count, status
   );
`else
   modport master (
      output load_en, opcode, operand_a, operand_b, out_ready,
      input  load_ready, out_valid, alu_out, instruction_word, count
   );
   modport slave (
      input  load_en, opcode, operand_a, operand_b, out_ready,
      output load_ready, out_valid, alu_out, instruction_word, count
   );
`endif
endinterface

// File: rtl/alu_iter_divider.sv
// rtl/alu_iter_divider.sv - restoring divider on operand magnitudes, OP_W steps, signed fix-up
module alu_iter_divider #(
   parameter int OP_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic signed [OP_W-1:0] dividend,
   input  logic signed [OP_W-1:0] divisor,
   output logic                   busy,
   output logic                   done,
   output logic signed [2*OP_W-1:0] quotient,
   output logic signed [2*OP_W-1:0] remainder
);
   localparam int CW = $clog2(OP_W + 1);

   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;

   logic [OP_W:0]   shifted, diff;
   logic            fits;
   logic [OP_W-1:0] rem_step, quo_step;
   logic [2*OP_W-1:0] quo_mag, rem_mag;

   function automatic logic [OP_W-1:0] mag(logic signed [OP_W-1:0] x);
      return x[OP_W-1] ? (~x + 1'b1) : x;
   endfunction

   // One restoring step; the last step's result is presented combinationally while done is high.
   always_comb begin
      shifted  = {rem_q, quo_q[OP_W-1]};
      diff     = shifted - {1'b0, dsr_q};
      fits     = (shifted >= {1'b0, dsr_q});
      rem_step = fits ? diff[OP_W-1:0] : shifted[OP_W-1:0];
      quo_step = {quo_q[OP_W-2:0], fits};
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dsr_d  = dsr_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      dbz_d  = dbz_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(OP_W);
         rem_d  = '0;
         quo_d  = mag(dividend);
         dsr_d  = mag(divisor);
         qneg_d = dividend[OP_W-1] ^ divisor[OP_W-1];
         rneg_d = dividend[OP_W-1];
         dbz_d  = (divisor == '0);
      end else if (busy_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dsr_q  <= dsr_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         dbz_q  <= dbz_d;
      end
   end

   always_comb begin
      quo_mag   = {{OP_W{1'b0}}, quo_step};
      rem_mag   = {{OP_W{1'b0}}, rem_step};
      busy      = busy_q;
      done      = busy_q && (cnt_q == CW'(1));
      quotient  = dbz_q ? '0 : (qneg_q ? -quo_mag : quo_mag);
      remainder = dbz_q ? '0 : (rneg_q ? -rem_mag : rem_mag);
   end
endmodule

// File: rtl/alu_instr_pipe.sv
// rtl/alu_instr_pipe.sv - instruction FIFO feeding an in-order ALU with valid/ready results; ALU_STATUS_EN adds status
module alu_instr_pipe
   import alu_opcodes_pkg::*;
#(
   parameter int OP_W  = 8,
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             reset,
   alu_instr_pipe_if.slave bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int RES_W  = 2 * OP_W;
   localparam int WORD_W = OPCODE_W + 2 * OP_W;

   typedef logic [WORD_W-1:0]       word_t;
   typedef logic signed [RES_W-1:0] res_t;

   word_t              mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   alu_state_t         state_q, state_d;
   word_t              exec_q, exec_d;
   res_t               result_q, result_d;

   logic               load_ready, push, pop, capture, div_start;
   word_t              head;
   opcode_t            head_op, exec_op;
   logic signed [OP_W-1:0] exec_a, exec_b;
   res_t               sa, sb, alu_res;
   logic               div_busy, div_done;
   res_t               div_quo, div_rem;

   assign load_ready = (count_q != CNT_W'(DEPTH));
   assign push       = bus.load_en && load_ready;
   assign head       = mem_q[rd_ptr_q];
   assign head_op    = opcode_t'(head[WORD_W-1 -: OPCODE_W]);
   assign exec_op    = opcode_t'(exec_q[WORD_W-1 -: OPCODE_W]);
   assign exec_a     = exec_q[2*OP_W-1 -: OP_W];
   assign exec_b     = exec_q[OP_W-1:0];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {bus.opcode, bus.operand_a, bus.operand_b};
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (count_q != '0) state_d = EXEC;
         EXEC: if (!is_divide(exec_op) || div_done) state_d = DONE;
         DONE: if (bus.out_ready) state_d = (count_q != '0) ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Popping straight out of DONE keeps back-to-back results one EXEC cycle apart.
   always_comb begin
      pop     = (count_q != '0) &&
                ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
      capture = (state_q == EXEC) && (!is_divide(exec_op) || div_done);
      bus.out_valid = (state_q == DONE);
   end

   assign div_start = pop && is_divide(head_op) && !div_busy;

   alu_iter_divider #(.OP_W(OP_W)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .dividend  (head[2*OP_W-1 -: OP_W]),
      .divisor   (head[OP_W-1:0]),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      sa = {{OP_W{exec_a[OP_W-1]}}, exec_a};
      sb = {{OP_W{exec_b[OP_W-1]}}, exec_b};
      case (exec_op)
         PASSA:   alu_res = sa;
         PASSB:   alu_res = sb;
         ADD:     alu_res = sa + sb;
         SUB:     alu_res = sa - sb;
         MULT:    alu_res = sa * sb;
         DIV:     alu_res = div_quo;
         MOD:     alu_res = div_rem;
         default: alu_res = '0;
      endcase
      exec_d   = pop ? head : exec_q;
      result_d = capture ? alu_res : result_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         exec_q   <= '0;
         result_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         exec_q   <= exec_d;
         result_q <= result_d;
      end
   end

   assign bus.load_ready       = load_ready;
   assign bus.alu_out          = result_q;
   assign bus.instruction_word = exec_q;
   assign bus.count            = count_q;

`ifdef ALU_STATUS_EN
   logic dbz_q, dbz_d, drop_q, drop_d;

   always_comb begin
      dbz_d  = capture ? (is_divide(exec_op) && (exec_b == '0)) : dbz_q;
      drop_d = drop_q | (bus.load_en & ~load_ready);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dbz_q  <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         dbz_q  <= dbz_d;
         drop_q <= drop_d;
      end
   end

   assign bus.status = {drop_q, dbz_q};
`endif
endmodule

// File: tb/tb_alu_instr_pipe.sv
// tb/tb_alu_instr_pipe.sv - self-checking bench: directed cases plus randomized traffic against a queue model
module tb_alu_instr_pipe;
   import alu_opcodes_pkg::*;

   localparam int OP_W  = 8;
   localparam int DEPTH = 4;

   typedef struct {
      opcode_t                op;
      logic signed [OP_W-1:0] a;
      logic signed [OP_W-1:0] b;
   } instr_t;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_acc    = 0;
   instr_t exp_q[$];
   longint obs_q[$];

   alu_instr_pipe_if #(.OP_W(OP_W), .DEPTH(DEPTH)) bus ();

   alu_instr_pipe #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_alu(opcode_t op, int a, int b);
      case (op)
         ZERO:  return 0;
         PASSA: return a;
         PASSB: return b;
         ADD:   return a + b;
         SUB:   return a - b;
         MULT:  return a * b;
         DIV:   return (b == 0) ? 0 : a / b;
         MOD:   return (b == 0) ? 0 : a % b;
         default: return 0;
      endcase
   endfunction

   function automatic longint obs_at(int i);
      return (obs_q.size() > i) ? obs_q[i] : 64'sh7fff_ffff_ffff;
   endfunction

   // Scoreboard: accepted pushes enter the model queue, every result handshake must match its head.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: got %0d, expected no result", $signed(bus.alu_out));
            end else begin
               instr_t e;
               e = exp_q.pop_front();
               chk("alu_out", $signed(bus.alu_out), model_alu(e.op, int'(e.a), int'(e.b)));
               chk("instruction_word", bus.instruction_word, {e.op, e.a, e.b});
            end
            obs_q.push_back(longint'($signed(bus.alu_out)));
         end
         if (bus.load_en && bus.load_ready) begin
            exp_q.push_back('{bus.opcode, bus.operand_a, bus.operand_b});
            n_acc++;
         end
         chk("load_ready_rule", bus.load_ready, (bus.count != DEPTH));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input opcode_t op, input int a, input int b);
      bus.load_en   = 1'b1;
      bus.opcode    = op;
      bus.operand_a = OP_W'(a);
      bus.operand_b = OP_W'(b);
      step();
      bus.load_en = 1'b0;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      @(negedge clk);
      while (!bus.out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         @(negedge clk);
      end
      if (!bus.out_valid) chk("wait_valid_timeout", edges, -1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 400) begin
         step();
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic timed_op(input string name, input opcode_t op, input int a, input int b,
                           input int exp_edges, input int exp_val);
      int edges;
      bus.out_ready = 1'b1;
      push(op, a, b);
      wait_valid(edges);
      chk({name, "_latency"}, edges, exp_edges);
      chk({name, "_value"}, $signed(bus.alu_out), exp_val);
      step();
   endtask

   function automatic int pick_operand();
      case ($urandom_range(0, 5))
         0: return -(2 ** (OP_W - 1));
         1: return -1;
         2: return 0;
         3: return 2 ** (OP_W - 1) - 1;
         default: return $urandom_range(0, 2 ** OP_W - 1) - 2 ** (OP_W - 1);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int edges, stale, acc0;
      bus.load_en   = 1'b0;
      bus.opcode    = ZERO;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_alu_out", bus.alu_out, 0);
      chk("rst_instr", bus.instruction_word, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_load_ready", bus.load_ready, 1);
      step();
      reset = 1'b1;
      step();

      // Back-to-back arithmetic with extreme operands.
      obs_q.delete();
      bus.out_ready = 1'b1;
      push(ADD, 127, 1);
      push(MULT, -128, -128);
      push(SUB, -128, 127);
      drain();
      chk("seq_n", obs_q.size(), 3);
      chk("seq_add", obs_at(0), 128);
      chk("seq_mult", obs_at(1), 16384);
      chk("seq_sub", obs_at(2), -255);

      timed_op("passb", PASSB, 3, -5, 2, -5);
      timed_op("div", DIV, -7, 2, OP_W + 1, -3);
      timed_op("mod", MOD, -7, 2, OP_W + 1, -1);
      timed_op("divneg1", DIV, -128, -1, OP_W + 1, 128);
      timed_op("div0", DIV, 5, 0, OP_W + 1, 0);
`ifdef ALU_STATUS_EN
      @(negedge clk);
      chk("status_dbz_clear_next", bus.status[0], 1);
`endif

      // Reset in the middle of a divide.
      push(DIV, 100, 3);
      step();
      step();
      step();
      reset = 1'b0;
      exp_q.delete();
      step();
      step();
      @(negedge clk);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_count", bus.count, 0);
      chk("midrst_load_ready", bus.load_ready, 1);
      chk("midrst_alu_out", bus.alu_out, 0);
      step();
      reset = 1'b1;
      stale = 0;
      for (int i = 0; i < OP_W + 4; i++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
         step();
      end
      chk("midrst_no_stale", stale, 0);

      // Full FIFO behind a held result; extra pushes dropped.
      bus.out_ready = 1'b0;
      push(ADD, 1, 2);
      wait_valid(edges);
      step();
      acc0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         bus.load_en   = 1'b1;
         bus.opcode    = MULT;
         bus.operand_a = OP_W'(i + 1);
         bus.operand_b = OP_W'(-3);
         step();
      end
      bus.load_en = 1'b0;
      @(negedge clk);
      chk("full_count", bus.count, DEPTH);
      chk("full_load_ready", bus.load_ready, 0);
      chk("full_accepted", n_acc - acc0, 4);
`ifdef ALU_STATUS_EN
      chk("status_drop", bus.status[1], 1);
`endif
      obs_q.delete();
      step();
      drain();
      chk("full_n", obs_q.size(), 5);
      chk("full_r0", obs_at(0), 3);
      chk("full_r1", obs_at(1), -3);
      chk("full_r4", obs_at(4), -12);

      // Held result stability and simultaneous push/pop.
      bus.out_ready = 1'b0;
      push(ADD, 10, 20);
      wait_valid(edges);
      step();
      push(PASSA, 5, 0);
      push(PASSB, 0, 7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_alu_out", $signed(bus.alu_out), 30);
         chk("hold_instr", bus.instruction_word, {ADD, 8'sd10, 8'sd20});
         chk("hold_count", bus.count, 2);
         step();
      end
      bus.out_ready = 1'b1;
      bus.load_en   = 1'b1;
      bus.opcode    = PASSA;
      bus.operand_a = OP_W'(-9);
      bus.operand_b = '0;
      step();
      bus.load_en   = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("pushpop_count", bus.count, 2);
      step();
      drain();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bus.load_en   = ($urandom_range(0, 1) == 1);
         bus.opcode    = opcode_t'($urandom_range(0, 7));
         bus.operand_a = OP_W'(pick_operand());
         bus.operand_b = OP_W'(pick_operand());
         bus.out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      bus.load_en = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
